// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command issuer for the 32-bit accumulator ALU.
// Buffers a program of opcode/operand pairs loaded through a ready/valid port.
// On start it clears the ALU accumulator, then issues each instruction and
// captures each result. Execution halts on an ADD carry-out or a zero divisor.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   load_valid/load_ready           program entry handshake
//   load_opcode/load_operand        entry contents (opcode, operand A)
//   start                           begin execution (sampled in IDLE)
//   busy, done                      activity level / completion pulse
//   err_halt, err_code              sticky halt flag, 01 add carry / 10 zero div
//   result_valid/data/index         per-instruction result pulse
//   alu_opcode/alu_a/alu_b/alu_reset  drive to the ALU
//   alu_c, alu_err                  ALU accumulator and carry flag
module alu_cmd_issuer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [3:0]               load_opcode,
  input  logic [WIDTH-1:0]         load_operand,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err_halt,
  output logic [1:0]               err_code,
  output logic                     result_valid,
  output logic [WIDTH-1:0]         result_data,
  output logic [$clog2(DEPTH)-1:0] result_index,
  output logic [3:0]               alu_opcode,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_reset,
  input  logic [WIDTH-1:0]         alu_c,
  input  logic                     alu_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_REM = 4'b0101;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, CAPTURE, DONE, HALT} state_t;

  state_t            state;
  logic [3:0]        mem_op [DEPTH];
  logic [WIDTH-1:0]  mem_a  [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, index;
  logic [AW:0]       count;
  logic [3:0]        issued_op;
  logic              zdiv;

  logic [3:0]        head_op;
  logic [WIDTH-1:0]  head_a;
  logic              head_zdiv, push, enter_issue, add_carry;

  assign alu_b      = alu_c;
  assign load_ready = (state == IDLE) && (count < FULL);
  assign push       = load_valid && load_ready;
  assign head_op    = mem_op[rd_ptr];
  assign head_a     = mem_a[rd_ptr];
  assign head_zdiv  = ((head_op == OP_DIV) || (head_op == OP_REM)) && (head_a == '0);
  assign add_carry  = (issued_op == OP_ADD) && alu_err;

  // The ALU drive for ISSUE is registered, so the FIFO head is examined (and
  // popped) on the edge that enters ISSUE rather than the one that leaves it.
  always_comb begin
    enter_issue = 1'b0;
    if (count != '0) begin
      if (state == CLEAR)
        enter_issue = 1'b1;
      else if (state == CAPTURE && !add_carry)
        enter_issue = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr] <= load_opcode;
      mem_a[wr_ptr]  <= load_operand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      index        <= '0;
      issued_op    <= '0;
      zdiv         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_halt     <= 1'b0;
      err_code     <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_index <= '0;
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_reset    <= 1'b0;
    end else begin
      done         <= 1'b0;
      result_valid <= 1'b0;
      alu_reset    <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end

      if (enter_issue) begin
        // A zero divisor is never handed to the ALU: hold and leave it queued.
        alu_opcode <= head_zdiv ? OP_NOP : head_op;
        alu_a      <= head_a;
        issued_op  <= head_op;
        zdiv       <= head_zdiv;
        if (!head_zdiv) begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            alu_reset <= 1'b1;
            err_halt  <= 1'b0;
            err_code  <= '0;
            index     <= '0;
          end
        end
        CLEAR: begin
          if (count != '0) begin
            state <= ISSUE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        ISSUE: begin
          alu_opcode <= OP_NOP;
          alu_a      <= '0;
          if (zdiv) begin
            state    <= HALT;
            err_code <= 2'b10;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          result_valid <= 1'b1;
          result_data  <= alu_c;
          result_index <= index;
          index        <= index + 1'b1;
          if (add_carry) begin
            state    <= HALT;
            err_code <= 2'b01;
          end else if (count != '0) begin
            state <= ISSUE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        HALT: begin
          count    <= '0;
          rd_ptr   <= '0;
          wr_ptr   <= '0;
          err_halt <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench for alu_cmd_issuer with a behavioural
// accumulator ALU (C <= B op A, B = C; carry flag updated by ADD only).
// Opcodes used by the ALU model: 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 REM, 6 AND, F load 0.
module tb_alu_cmd_issuer;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [3:0]        load_opcode = '0;
  logic [WIDTH-1:0]  load_operand = '0;
  logic              start = 1'b0;
  logic              busy, done, err_halt;
  logic [1:0]        err_code;
  logic              result_valid;
  logic [WIDTH-1:0]  result_data;
  logic [3:0]        result_index;
  logic [3:0]        alu_opcode;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_c;
  logic              alu_reset, alu_err;

  logic [WIDTH-1:0]  acc = '0;
  logic              cf = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int s0 = 0;
  bit running = 1'b0;
  int rel;

  logic [WIDTH-1:0] res_data [$];
  int               res_idx  [$];
  int               res_cyc  [$];
  int               done_cnt;
  int               done_cyc;
  logic [3:0]       op_log   [64];
  logic             rst_log  [64];
  logic             busy_log [64];
  logic             eh_log   [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_issuer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_opcode(load_opcode), .load_operand(load_operand),
    .start(start), .busy(busy), .done(done),
    .err_halt(err_halt), .err_code(err_code),
    .result_valid(result_valid), .result_data(result_data),
    .result_index(result_index),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_reset(alu_reset), .alu_c(alu_c), .alu_err(alu_err)
  );

  // Behavioural accumulator ALU
  assign alu_c   = acc;
  assign alu_err = cf;
  always @(posedge clk) begin
    if (alu_reset) begin
      acc <= '0;
      cf  <= 1'b0;
    end else begin
      case (alu_opcode)
        4'h1: {cf, acc} <= {1'b0, alu_b} + {1'b0, alu_a};
        4'h2: acc <= alu_b - alu_a;
        4'h3: acc <= alu_b * alu_a;
        4'h4: if (alu_a != '0) acc <= alu_b / alu_a;
        4'h5: if (alu_a != '0) acc <= alu_b % alu_a;
        4'h6: acc <= alu_b & alu_a;
        4'hF: acc <= '0;
        default: ;
      endcase
    end
  end

  // Mid-cycle monitor; rel is the cycle number with start sampled at edge 0.
  always @(negedge clk) begin
    if (running) begin
      rel = cyc - s0 + 1;
      if (rel >= 0 && rel < 64) begin
        op_log[rel]   = alu_opcode;
        rst_log[rel]  = alu_reset;
        busy_log[rel] = busy;
        eh_log[rel]   = err_halt;
      end
      if (result_valid) begin
        res_data.push_back(result_data);
        res_idx.push_back(int'(result_index));
        res_cyc.push_back(rel);
      end
      if (done) begin
        done_cnt++;
        done_cyc = rel;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    res_data.delete();
    res_idx.delete();
    res_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      op_log[i]   = 4'hE;
      rst_log[i]  = 1'bx;
      busy_log[i] = 1'bx;
      eh_log[i]   = 1'bx;
    end
  endtask

  // Called just after a rising edge; offers one entry for one cycle.
  task automatic load_entry(input logic [3:0] op, input logic [31:0] a, output bit accepted);
    load_valid   = 1'b1;
    load_opcode  = op;
    load_operand = a;
    @(negedge clk);
    accepted = load_ready;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic run_prog(input bit with_load, input logic [3:0] op, input logic [31:0] a);
    clear_logs();
    start = 1'b1;
    if (with_load) begin
      load_valid   = 1'b1;
      load_opcode  = op;
      load_operand = a;
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    load_valid = 1'b0;
    s0         = cyc;
    running    = 1'b1;
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("run_ends", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    running = 1'b0;
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_busy"},         64'(busy),         64'd0);
    check({p, "_done"},         64'(done),         64'd0);
    check({p, "_err_halt"},     64'(err_halt),     64'd0);
    check({p, "_err_code"},     64'(err_code),     64'd0);
    check({p, "_result_valid"}, 64'(result_valid), 64'd0);
    check({p, "_result_data"},  64'(result_data),  64'd0);
    check({p, "_result_index"}, 64'(result_index), 64'd0);
    check({p, "_alu_opcode"},   64'(alu_opcode),   64'd0);
    check({p, "_alu_a"},        64'(alu_a),        64'd0);
    check({p, "_alu_reset"},    64'(alu_reset),    64'd0);
    check({p, "_load_ready"},   64'(load_ready),   64'd1);
  endtask

  logic [31:0] e1 [5] = '{32'd5, 32'd4, 32'd12, 32'd4, 32'd1};
  bit acc_ok;
  int n_acc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("rst");

    // T1: ADD 5, SUB 1, MUL 3, DIV 3, REM 3 (last loaded together with start)
    load_entry(4'h1, 32'd5, acc_ok);
    load_entry(4'h2, 32'd1, acc_ok);
    load_entry(4'h3, 32'd3, acc_ok);
    load_entry(4'h4, 32'd3, acc_ok);
    run_prog(1'b1, 4'h5, 32'd3);
    check("t1_nres", 64'(res_data.size()), 64'd5);
    for (int k = 0; k < 5 && k < res_data.size(); k++) begin
      check($sformatf("t1_data%0d", k), 64'(res_data[k]), 64'(e1[k]));
      check($sformatf("t1_idx%0d", k),  64'(res_idx[k]),  64'(k));
      check($sformatf("t1_cyc%0d", k),  64'(res_cyc[k]),  64'(4 + 2*k));
    end
    check("t1_done_cnt",  64'(done_cnt),    64'd1);
    check("t1_done_cyc",  64'(done_cyc),    64'd12);
    check("t1_clear",     64'(rst_log[1]),  64'd1);
    check("t1_issue_op",  64'(op_log[2]),   64'h1);
    check("t1_capt_op",   64'(op_log[3]),   64'h0);
    check("t1_busy12",    64'(busy_log[12]), 64'd1);
    check("t1_busy13",    64'(busy_log[13]), 64'd0);
    check("t1_err_halt",  64'(err_halt),    64'd0);
    check("t1_err_code",  64'(err_code),    64'd0);

    // T5: 17 offers into a 16-entry buffer (pointers start at 5, so they wrap)
    n_acc = 0;
    for (int k = 0; k < 17; k++) begin
      load_entry(4'h1, (k == 16) ? 32'd100 : 32'(k + 1), acc_ok);
      if (acc_ok) n_acc++;
    end
    check("t5_accepted",   64'(n_acc),      64'd16);
    check("t5_17th_ready", 64'(acc_ok),     64'd0);
    check("t5_full_ready", 64'(load_ready), 64'd0);
    run_prog(1'b0, 4'h0, 32'd0);
    check("t5_nres", 64'(res_data.size()), 64'd16);
    for (int k = 0; k < 16 && k < res_data.size(); k++) begin
      check($sformatf("t5_data%0d", k), 64'(res_data[k]), 64'((k + 1) * (k + 2) / 2));
      check($sformatf("t5_idx%0d", k),  64'(res_idx[k]),  64'(k));
    end
    check("t5_done_cyc", 64'(done_cyc), 64'd34);

    // T2: ADD FFFFFFFF, ADD 2 (carry), AND FF never issued
    load_entry(4'h1, 32'hFFFF_FFFF, acc_ok);
    load_entry(4'h1, 32'd2, acc_ok);
    load_entry(4'h6, 32'hFF, acc_ok);
    run_prog(1'b0, 4'h0, 32'd0);
    check("t2_nres", 64'(res_data.size()), 64'd2);
    if (res_data.size() >= 2) begin
      check("t2_data0", 64'(res_data[0]), 64'hFFFF_FFFF);
      check("t2_data1", 64'(res_data[1]), 64'h1);
    end
    check("t2_err_code",   64'(err_code),   64'd1);
    check("t2_err_halt",   64'(err_halt),   64'd1);
    check("t2_done_cnt",   64'(done_cnt),   64'd0);
    check("t2_load_ready", 64'(load_ready), 64'd1);

    // T3: empty buffer (also shows the halted program was flushed)
    run_prog(1'b0, 4'h0, 32'd0);
    check("t3_nres",     64'(res_data.size()), 64'd0);
    check("t3_done_cnt", 64'(done_cnt),        64'd1);
    check("t3_done_cyc", 64'(done_cyc),        64'd2);
    check("t3_clear",    64'(rst_log[1]),      64'd1);
    check("t3_err_halt", 64'(err_halt),        64'd0);
    check("t3_err_code", 64'(err_code),        64'd0);

    // T4: ADD 7, DIV 0
    load_entry(4'h1, 32'd7, acc_ok);
    load_entry(4'h4, 32'd0, acc_ok);
    run_prog(1'b0, 4'h0, 32'd0);
    check("t4_nres", 64'(res_data.size()), 64'd1);
    if (res_data.size() >= 1) begin
      check("t4_data0", 64'(res_data[0]), 64'd7);
      check("t4_cyc0",  64'(res_cyc[0]),  64'd4);
    end
    check("t4_add_issue", 64'(op_log[2]),  64'h1);
    check("t4_div_slot",  64'(op_log[4]),  64'h0);
    check("t4_halt_op",   64'(op_log[5]),  64'h0);
    check("t4_busy5",     64'(busy_log[5]), 64'd1);
    check("t4_busy6",     64'(busy_log[6]), 64'd0);
    check("t4_eh5",       64'(eh_log[5]),  64'd0);
    check("t4_eh6",       64'(eh_log[6]),  64'd1);
    check("t4_err_code",  64'(err_code),   64'd2);
    check("t4_err_halt",  64'(err_halt),   64'd1);
    check("t4_done_cnt",  64'(done_cnt),   64'd0);

    // T6: reset during CAPTURE of instruction 2 of 5
    for (int k = 0; k < 5; k++) load_entry(4'h1, 32'd1, acc_ok);
    clear_logs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    s0      = cyc;
    running = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_pre_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("t6");
    repeat (10) @(posedge clk);
    #1;
    running = 1'b0;
    check("t6_nres", 64'(res_data.size()), 64'd2);
    run_prog(1'b0, 4'h0, 32'd0);
    check("t6_after_nres",     64'(res_data.size()), 64'd0);
    check("t6_after_done_cyc", 64'(done_cyc),        64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command issuer for the 32-bit accumulator ALU (4-bit opcode, operand A, accumulator fed back as B, registered result C, registered carry-error flag). It buffers a short program of opcode/operand pairs loaded through a ready/valid port. On `start` it clears the ALU accumulator, issues each instruction and captures each result. Execution halts on an ADD carry-out or a zero divisor. It replaces hand-driven stimulus as the block that drives the ALU's input side.

## Interface
Parameters:
- DEPTH, 16, program buffer entries (power of 2, ≥2)
- WIDTH, 32, operand/result width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- load_valid  in  1  program entry offered
- load_ready  out  1  entry accepted when load_valid & load_ready
- load_opcode  in  4  ALU opcode of entry
- load_operand  in  WIDTH  operand A of entry
- start  in  1  begin execution (sampled in IDLE only)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse: program completed without error
- err_halt  out  1  sticky: execution halted on error
- err_code  out  2  01 add carry, 10 zero divisor, 00 none
- result_valid  out  1  one-cycle pulse per completed instruction
- result_data  out  WIDTH  ALU result C for that instruction
- result_index  out  $clog2(DEPTH)  program position, 0-based
- alu_opcode  out  4  to ALU opcode
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B; always equals alu_c
- alu_reset  out  1  to ALU reset (active-high)
- alu_c  in  WIDTH  ALU accumulator output
- alu_err  in  1  ALU registered carry flag

## Operation
- Program buffer: FIFO with wr_ptr, rd_ptr and count (0..DEPTH).
- load_ready = (state==IDLE) && (count<DEPTH). Entries are consumed as they are issued.
- States: IDLE, CLEAR, ISSUE, CAPTURE, DONE, HALT.
- IDLE: alu_opcode=0000 (ALU holds), alu_a=0, alu_reset=0. On start, go to CLEAR. start also clears err_halt, err_code and the index counter to 0.
- CLEAR: alu_reset=1 for exactly one cycle, zeroing the accumulator. Next state is ISSUE if count>0, else DONE.
- ISSUE: drive alu_opcode and alu_a from the FIFO head. Pop the entry and latch its opcode as issued_op. Next state is CAPTURE.
  - Zero-divisor precheck: if the head opcode is 0100 or 0101 and the operand is 0, drive alu_opcode=0000 and do not pop. Set err_code=10 and go to HALT.
- CAPTURE: alu_opcode=0000. The result is now on alu_c.
  - Register result_valid=1, result_data=alu_c and result_index=index; then index++.
  - If issued_op==0001 and alu_err==1: set err_code=01 and go to HALT. The result is still reported.
  - Otherwise go to ISSUE if count>0, else DONE.
  - alu_err is ignored for every other opcode.
- DONE: done=1 for one cycle, then IDLE.
- HALT: flush the FIFO (count, rd_ptr, wr_ptr to 0) and set err_halt=1. Then go to IDLE. err_halt and err_code are held until the next start or reset.
- Opcode 1111 is issued like any other opcode (the ALU loads 0). Opcode 0000 is a legal program no-op and produces a result equal to the unchanged accumulator.
- Width rule: results are taken modulo 2^WIDTH as produced by the ALU; no sign interpretation.

## Timing
- Reset values:
  - state=IDLE, count=0, pointers=0, index=0
  - busy=0, done=0, err_halt=0, err_code=00
  - result_valid=0, result_data=0, result_index=0
  - alu_opcode=0000, alu_a=0, alu_reset=0
  - load_ready=1
- Reset mid-run returns to IDLE the next cycle and discards the program. Because alu_reset is not asserted by reset itself, the ALU accumulator is left as is.
- Latency with start sampled at edge 0 and N instructions:
  - CLEAR occupies cycle 1.
  - Instruction k (0-based) is in ISSUE at cycle 2+2k and in CAPTURE at cycle 3+2k.
  - result_valid for k is high in cycle 4+2k.
  - done is high in cycle 2N+2.
  - busy falls in cycle 2N+3.
- Zero divisor at instruction k: HALT at cycle 3+2k, err_halt high from cycle 4+2k. No result is emitted for k.
- load_valid while busy is not accepted (load_ready=0). start while busy is ignored.
- Simultaneous load and start in IDLE: the load is accepted and start is taken in the same cycle, so the new entry is included.
- Full buffer: load_ready=0 at count==DEPTH.
- Pointer wrap-around is modulo DEPTH.

## Test plan
- Load ADD 5, SUB 1, MUL 3, DIV 3, REM 3; start -> results 5,4,12,4,1 at indices 0..4; done pulse in cycle 12; err_halt=0.
- Load ADD FFFFFFFF, ADD 2, AND FF; start -> results FFFFFFFF then 1; err_code=01, err_halt=1, no third result, no done, FIFO empty.
- Load ADD 7, DIV 0; start -> result 7 only; err_code=10, err_halt=1; alu_opcode stays 0000 throughout the DIV slot.
- Load 17 entries back-to-back -> first 16 accepted, load_ready=0 on 17th; execute, then the next program wraps the pointers and runs correctly.
- Start with empty buffer -> CLEAR cycle with alu_reset=1, done in cycle 2, no result_valid.
- Assert reset during CAPTURE of instruction 2 of 5 -> next cycle IDLE, busy=0, count=0, all outputs at reset values, no further results.
